// File: rtl/thread_sched_pkg.sv
// -----------------------------------------------------------------------------
// thread_sched_pkg
//   Shared definitions for the 4-thread issue scheduler: thread count,
//   one-hot thread type and a one-hot qualifier for thread selects.
// -----------------------------------------------------------------------------
package thread_sched_pkg;

  localparam int NUM_THREADS = 4;

  // One bit per hardware thread; exactly one bit set names a single thread.
  typedef logic [NUM_THREADS-1:0] thr_oh_t;

  // Binary thread index.
  typedef logic [1:0] thr_idx_t;

  // True when exactly one of the four thread bits is set.
  function automatic logic is_onehot4(input thr_oh_t v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return (cnt == 3'd1);
  endfunction

endpackage

// File: rtl/thread_sched_if.sv
// -----------------------------------------------------------------------------
// thread_sched_if
//   Bundle between EX/control (master) and the issue scheduler (slave).
//   master drives : run, stall, thread_en, redirect_{valid,thread,pc},
//                   halt_{valid,thread}
//   slave drives  : pc_IF, thread_sel_IF, valid_IF, pc_ID, thread_sel_ID,
//                   valid_ID
// -----------------------------------------------------------------------------
interface thread_sched_if #(
  parameter int PC_WIDTH = 9
);
  import thread_sched_pkg::*;

  logic                run;
  logic                stall;
  thr_oh_t             thread_en;
  logic                redirect_valid;
  thr_oh_t             redirect_thread;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                halt_valid;
  thr_oh_t             halt_thread;

  logic [PC_WIDTH-1:0] pc_IF;
  thr_oh_t             thread_sel_IF;
  logic                valid_IF;
  logic [PC_WIDTH-1:0] pc_ID;
  thr_oh_t             thread_sel_ID;
  logic                valid_ID;

  modport master (
    output run, stall, thread_en,
    output redirect_valid, redirect_thread, redirect_pc,
    output halt_valid, halt_thread,
    input  pc_IF, thread_sel_IF, valid_IF,
    input  pc_ID, thread_sel_ID, valid_ID
  );

  modport slave (
    input  run, stall, thread_en,
    input  redirect_valid, redirect_thread, redirect_pc,
    input  halt_valid, halt_thread,
    output pc_IF, thread_sel_IF, valid_IF,
    output pc_ID, thread_sel_ID, valid_ID
  );

endinterface

// File: rtl/thread_sched_chk.sv
// -----------------------------------------------------------------------------
// thread_sched_chk
//   Simulation checks on the scheduler's control inputs. A redirect or halt
//   whose thread field is not one-hot is dropped by the scheduler; these
//   properties flag the upstream logic that produced it.
//   clk_i, reset_i          : scheduler clock / synchronous reset
//   redirect_valid_i/_thread_i, halt_valid_i/_thread_i : observed controls
// -----------------------------------------------------------------------------
module thread_sched_chk
  import thread_sched_pkg::*;
(
  input logic    clk_i,
  input logic    reset_i,
  input logic    redirect_valid_i,
  input thr_oh_t redirect_thread_i,
  input logic    halt_valid_i,
  input thr_oh_t halt_thread_i
);

  redirect_onehot_a: assert property (
    @(posedge clk_i) disable iff (reset_i)
    redirect_valid_i |-> $onehot(redirect_thread_i));

  halt_onehot_a: assert property (
    @(posedge clk_i) disable iff (reset_i)
    halt_valid_i |-> $onehot(halt_thread_i));

endmodule

// File: rtl/thread_sched_rr_arb4.sv
// -----------------------------------------------------------------------------
// rr_arb4
//   Combinational 4-way round-robin picker. Scans req starting one past the
//   last winner and wraps around, so the last winner has lowest priority.
//   req_i  : request mask
//   last_i : index of the previous winner
//   gnt_o  : one-hot grant (zero when nothing requests)
//   idx_o  : binary index of the grant (0 when nothing requests)
//   any_o  : at least one request present
// -----------------------------------------------------------------------------
module rr_arb4
  import thread_sched_pkg::*;
(
  input  thr_oh_t  req_i,
  input  thr_idx_t last_i,
  output thr_oh_t  gnt_o,
  output thr_idx_t idx_o,
  output logic     any_o
);

  thr_idx_t start_s;
  thr_idx_t off_s;
  thr_oh_t  req_rot_s;

  // Rotate the request so the first candidate sits at bit 0, then priority-encode.
  always_comb begin
    start_s = last_i + 2'd1;
    for (int j = 0; j < NUM_THREADS; j++) begin
      req_rot_s[j] = req_i[start_s + 2'(j)];
    end
    casez (req_rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    any_o = |req_i;
    idx_o = any_o ? (start_s + off_s) : 2'd0;
    gnt_o = any_o ? (4'b0001 << idx_o) : 4'b0000;
  end

endmodule

// File: rtl/thread_sched.sv
// -----------------------------------------------------------------------------
// thread_sched
//   Fine-grained 4-thread issue scheduler. Keeps one PC per thread, issues
//   one thread per cycle round-robin over (active & thread_en), and carries
//   the issued slot through registered IF and ID stages. Redirects and halts
//   from EX retarget/deactivate a thread and kill its in-flight slot.
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   sif   : thread_sched_if.slave (controls in, IF/ID slot out)
// -----------------------------------------------------------------------------
module thread_sched
  import thread_sched_pkg::*;
#(
  parameter int PC_WIDTH      = 9,
  parameter int PC_BASE       = 'h000,
  parameter int THREAD_STRIDE = 'h080
) (
  input logic           clk,
  input logic           reset,
  thread_sched_if.slave sif
);

  // Start PC of a thread, wrapped to the PC width.
  function automatic logic [PC_WIDTH-1:0] start_pc(input int idx);
    return PC_WIDTH'(PC_BASE + idx * THREAD_STRIDE);
  endfunction

  logic [PC_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [PC_WIDTH-1:0] pc_d [NUM_THREADS];
  thr_oh_t             active_q, active_d;
  thr_idx_t            rr_last_q, rr_last_d;
  logic [PC_WIDTH-1:0] pc_if_q, pc_if_d;
  thr_oh_t             sel_if_q, sel_if_d;
  logic                valid_if_q, valid_if_d;
  logic [PC_WIDTH-1:0] pc_id_q, pc_id_d;
  thr_oh_t             sel_id_q, sel_id_d;
  logic                valid_id_q, valid_id_d;

  logic     redir_ok_s;
  logic     halt_ok_s;
  thr_oh_t  redir_mask_s;
  thr_oh_t  halt_mask_s;
  thr_oh_t  kill_mask_s;
  thr_oh_t  elig_s;
  thr_oh_t  arb_gnt_s;
  thr_idx_t arb_idx_s;
  logic     arb_any_s;
  logic     issue_s;
  logic     new_kill_s;
  logic     if_kill_s;

  // Qualify redirect/halt: a malformed thread field drops the command entirely.
  always_comb begin
    redir_ok_s   = sif.redirect_valid && is_onehot4(sif.redirect_thread);
    halt_ok_s    = sif.halt_valid && is_onehot4(sif.halt_thread);
    redir_mask_s = redir_ok_s ? sif.redirect_thread : 4'b0000;
    halt_mask_s  = halt_ok_s ? sif.halt_thread : 4'b0000;
    kill_mask_s  = redir_mask_s | halt_mask_s;
  end

  assign elig_s = active_q & sif.thread_en;

  rr_arb4 u_arb (
    .req_i  (elig_s),
    .last_i (rr_last_q),
    .gnt_o  (arb_gnt_s),
    .idx_o  (arb_idx_s),
    .any_o  (arb_any_s)
  );

  assign issue_s    = sif.run && !sif.stall && arb_any_s;
  // The slot being issued now, or the slot leaving IF, belongs to a killed thread.
  assign new_kill_s = |(arb_gnt_s & kill_mask_s);
  assign if_kill_s  = |(sel_if_q & kill_mask_s);

  // Per-thread PC update: a redirect beats the post-issue increment and is
  // taken even while stalled.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (redir_mask_s[i]) begin
        pc_d[i] = sif.redirect_pc;
      end else if (issue_s && arb_gnt_s[i]) begin
        pc_d[i] = pc_q[i] + PC_WIDTH'(1);
      end else begin
        pc_d[i] = pc_q[i];
      end
    end
  end

  // Issue and IF/ID pipeline next state; a stall freezes both stages and rr_last.
  always_comb begin
    active_d   = active_q & ~halt_mask_s;
    rr_last_d  = rr_last_q;
    pc_if_d    = pc_if_q;
    sel_if_d   = sel_if_q;
    valid_if_d = valid_if_q;
    pc_id_d    = pc_id_q;
    sel_id_d   = sel_id_q;
    valid_id_d = valid_id_q;
    if (sif.stall) begin
      rr_last_d = rr_last_q;
    end else begin
      if (issue_s) begin
        // A killed issue still reports the pre-redirect PC but carries no thread.
        pc_if_d    = pc_q[arb_idx_s];
        sel_if_d   = new_kill_s ? 4'b0000 : arb_gnt_s;
        valid_if_d = !new_kill_s;
        rr_last_d  = arb_idx_s;
      end else begin
        sel_if_d   = 4'b0000;
        valid_if_d = 1'b0;
      end
      pc_id_d    = pc_if_q;
      valid_id_d = valid_if_q && !if_kill_s;
      sel_id_d   = (valid_if_q && !if_kill_s) ? sel_if_q : 4'b0000;
    end
  end

  // State registers with synchronous reset to the per-thread start PCs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= start_pc(i);
      end
      active_q   <= 4'b1111;
      rr_last_q  <= 2'd3;
      pc_if_q    <= '0;
      sel_if_q   <= 4'b0000;
      valid_if_q <= 1'b0;
      pc_id_q    <= '0;
      sel_id_q   <= 4'b0000;
      valid_id_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= pc_d[i];
      end
      active_q   <= active_d;
      rr_last_q  <= rr_last_d;
      pc_if_q    <= pc_if_d;
      sel_if_q   <= sel_if_d;
      valid_if_q <= valid_if_d;
      pc_id_q    <= pc_id_d;
      sel_id_q   <= sel_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  assign sif.pc_IF         = pc_if_q;
  assign sif.thread_sel_IF = sel_if_q;
  assign sif.valid_IF      = valid_if_q;
  assign sif.pc_ID         = pc_id_q;
  assign sif.thread_sel_ID = sel_id_q;
  assign sif.valid_ID      = valid_id_q;

  thread_sched_chk u_chk (
    .clk_i             (clk),
    .reset_i           (reset),
    .redirect_valid_i  (sif.redirect_valid),
    .redirect_thread_i (sif.redirect_thread),
    .halt_valid_i      (sif.halt_valid),
    .halt_thread_i     (sif.halt_thread)
  );

endmodule

// File: tb/tb_thread_sched.sv
// -----------------------------------------------------------------------------
// tb_thread_sched
//   Directed bench for thread_sched. Instance "dut" uses the default start
//   PCs; instance "dut_w" starts thread 0 at 'h1FF to exercise PC wrap.
//   Inputs change 1 time unit after posedge; outputs are read at that point.
// -----------------------------------------------------------------------------
module tb_thread_sched;
  import thread_sched_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  thread_sched_if #(.PC_WIDTH(9)) m ();
  thread_sched_if #(.PC_WIDTH(9)) w ();

  thread_sched #(.PC_WIDTH(9), .PC_BASE('h000), .THREAD_STRIDE('h080)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (m)
  );

  thread_sched #(.PC_WIDTH(9), .PC_BASE('h1FF), .THREAD_STRIDE('h080)) dut_w (
    .clk   (clk),
    .reset (reset),
    .sif   (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m.run = 1'b0; m.stall = 1'b0; m.thread_en = 4'h0;
    m.redirect_valid = 1'b0; m.redirect_thread = 4'h0; m.redirect_pc = 9'h000;
    m.halt_valid = 1'b0; m.halt_thread = 4'h0;
    w.run = 1'b0; w.stall = 1'b0; w.thread_en = 4'h0;
    w.redirect_valid = 1'b0; w.redirect_thread = 4'h0; w.redirect_pc = 9'h000;
    w.halt_valid = 1'b0; w.halt_thread = 4'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    m.run = 1'b1; m.thread_en = 4'hF;
    repeat (3) step();
    reset = 1'b1;
    step();
    checks++;
    if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {4'h0, 9'h000, 1'b0}) begin
      errors++;
      $display("FAIL reset_if got=%h exp=%h", {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {4'h0, 9'h000, 1'b0});
    end
    checks++;
    if ({m.thread_sel_ID, m.pc_ID, m.valid_ID} !== {4'h0, 9'h000, 1'b0}) begin
      errors++;
      $display("FAIL reset_id got=%h exp=%h", {m.thread_sel_ID, m.pc_ID, m.valid_ID}, {4'h0, 9'h000, 1'b0});
    end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] es [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [8:0] ep [5] = '{9'h000, 9'h080, 9'h100, 9'h180, 9'h001};
    do_reset();
    m.run = 1'b1; m.thread_en = 4'hF;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {es[c], ep[c], 1'b1}) begin
        errors++;
        $display("FAIL rr_if c=%0d got=%h exp=%h", c, {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {es[c], ep[c], 1'b1});
      end
      checks++;
      if (c > 0) begin
        if ({m.thread_sel_ID, m.pc_ID, m.valid_ID} !== {es[c-1], ep[c-1], 1'b1}) begin
          errors++;
          $display("FAIL rr_id c=%0d got=%h exp=%h", c, {m.thread_sel_ID, m.pc_ID, m.valid_ID}, {es[c-1], ep[c-1], 1'b1});
        end
      end else begin
        if ({m.thread_sel_ID, m.pc_ID, m.valid_ID} !== {4'h0, 9'h000, 1'b0}) begin
          errors++;
          $display("FAIL rr_id_first got=%h exp=%h", {m.thread_sel_ID, m.pc_ID, m.valid_ID}, {4'h0, 9'h000, 1'b0});
        end
      end
    end
  endtask

  task automatic test_enable_mask();
    // Threads 0 and 2 only; then nothing; then all, showing pc[1]/pc[3] untouched.
    logic [3:0] es [4] = '{4'h1, 4'h4, 4'h1, 4'h4};
    logic [8:0] ep [4] = '{9'h000, 9'h100, 9'h001, 9'h101};
    logic [3:0] fs [4] = '{4'h8, 4'h1, 4'h2, 4'h4};
    logic [8:0] fp [4] = '{9'h180, 9'h002, 9'h080, 9'h102};
    do_reset();
    m.run = 1'b1; m.thread_en = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {es[c], ep[c], 1'b1}) begin
        errors++;
        $display("FAIL en5_if c=%0d got=%h exp=%h", c, {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {es[c], ep[c], 1'b1});
      end
    end
    m.thread_en = 4'h0;
    step();
    checks++;
    if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {4'h0, 9'h101, 1'b0}) begin
      errors++;
      $display("FAIL en0_idle got=%h exp=%h", {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {4'h0, 9'h101, 1'b0});
    end
    m.thread_en = 4'hF;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {fs[c], fp[c], 1'b1}) begin
        errors++;
        $display("FAIL enF_if c=%0d got=%h exp=%h", c, {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {fs[c], fp[c], 1'b1});
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    m.run = 1'b1; m.thread_en = 4'hF;
    step();
    step();
    // Thread 2 is the pick at the next edge; redirect it in that same cycle.
    m.redirect_valid = 1'b1; m.redirect_thread = 4'b0100; m.redirect_pc = 9'h1F0;
    step();
    m.redirect_valid = 1'b0; m.redirect_thread = 4'h0;
    checks++;
    if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {4'h0, 9'h100, 1'b0}) begin
      errors++;
      $display("FAIL redir_kill_if got=%h exp=%h", {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {4'h0, 9'h100, 1'b0});
    end
    step();
    checks++;
    if ({m.thread_sel_ID, m.pc_ID, m.valid_ID} !== {4'h0, 9'h100, 1'b0}) begin
      errors++;
      $display("FAIL redir_kill_id got=%h exp=%h", {m.thread_sel_ID, m.pc_ID, m.valid_ID}, {4'h0, 9'h100, 1'b0});
    end
    checks++;
    if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {4'h8, 9'h180, 1'b1}) begin
      errors++;
      $display("FAIL redir_next_if got=%h exp=%h", {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {4'h8, 9'h180, 1'b1});
    end
    step();
    step();
    step();
    checks++;
    if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {4'h4, 9'h1F0, 1'b1}) begin
      errors++;
      $display("FAIL redir_reissue got=%h exp=%h", {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {4'h4, 9'h1F0, 1'b1});
    end
  endtask

  task automatic test_halt();
    logic [3:0] es [5] = '{4'h8, 4'h1, 4'h4, 4'h8, 4'h1};
    logic [8:0] ep [5] = '{9'h180, 9'h001, 9'h101, 9'h181, 9'h002};
    do_reset();
    m.run = 1'b1; m.thread_en = 4'hF;
    step();
    step();
    // Thread 1 is in IF and moves to ID at this edge; halt kills it there.
    m.halt_valid = 1'b1; m.halt_thread = 4'b0010;
    step();
    m.halt_valid = 1'b0; m.halt_thread = 4'h0;
    checks++;
    if ({m.thread_sel_ID, m.pc_ID, m.valid_ID} !== {4'h0, 9'h080, 1'b0}) begin
      errors++;
      $display("FAIL halt_kill_id got=%h exp=%h", {m.thread_sel_ID, m.pc_ID, m.valid_ID}, {4'h0, 9'h080, 1'b0});
    end
    checks++;
    if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {4'h4, 9'h100, 1'b1}) begin
      errors++;
      $display("FAIL halt_if got=%h exp=%h", {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {4'h4, 9'h100, 1'b1});
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {es[c], ep[c], 1'b1}) begin
        errors++;
        $display("FAIL halt_order c=%0d got=%h exp=%h", c, {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {es[c], ep[c], 1'b1});
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    m.run = 1'b1; m.thread_en = 4'hF;
    step();
    step();
    m.stall = 1'b1;
    m.redirect_valid = 1'b1; m.redirect_thread = 4'b1000; m.redirect_pc = 9'h0AA;
    for (int c = 0; c < 3; c++) begin
      step();
      m.redirect_valid = 1'b0; m.redirect_thread = 4'h0;
      checks++;
      if ({m.thread_sel_IF, m.pc_IF, m.valid_IF, m.thread_sel_ID, m.pc_ID, m.valid_ID}
          !== {4'h2, 9'h080, 1'b1, 4'h1, 9'h000, 1'b1}) begin
        errors++;
        $display("FAIL stall_freeze c=%0d got=%h exp=%h", c,
                 {m.thread_sel_IF, m.pc_IF, m.valid_IF, m.thread_sel_ID, m.pc_ID, m.valid_ID},
                 {4'h2, 9'h080, 1'b1, 4'h1, 9'h000, 1'b1});
      end
    end
    m.stall = 1'b0;
    step();
    checks++;
    if ({m.thread_sel_IF, m.pc_IF, m.valid_IF, m.thread_sel_ID, m.pc_ID, m.valid_ID}
        !== {4'h4, 9'h100, 1'b1, 4'h2, 9'h080, 1'b1}) begin
      errors++;
      $display("FAIL stall_release got=%h exp=%h",
               {m.thread_sel_IF, m.pc_IF, m.valid_IF, m.thread_sel_ID, m.pc_ID, m.valid_ID},
               {4'h4, 9'h100, 1'b1, 4'h2, 9'h080, 1'b1});
    end
    step();
    checks++;
    if ({m.thread_sel_IF, m.pc_IF, m.valid_IF} !== {4'h8, 9'h0AA, 1'b1}) begin
      errors++;
      $display("FAIL stall_redir_pc got=%h exp=%h", {m.thread_sel_IF, m.pc_IF, m.valid_IF}, {4'h8, 9'h0AA, 1'b1});
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [8:0] ep [3] = '{9'h1FF, 9'h000, 9'h001};
    do_reset();
    w.run = 1'b1; w.thread_en = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({w.thread_sel_IF, w.pc_IF, w.valid_IF} !== {4'h1, ep[c], 1'b1}) begin
        errors++;
        $display("FAIL wrap_if c=%0d got=%h exp=%h", c, {w.thread_sel_IF, w.pc_IF, w.valid_IF}, {4'h1, ep[c], 1'b1});
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if ({w.thread_sel_IF, w.pc_IF, w.valid_IF, w.thread_sel_ID, w.pc_ID, w.valid_ID}
        !== {4'h0, 9'h000, 1'b0, 4'h0, 9'h000, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset got=%h exp=%h",
               {w.thread_sel_IF, w.pc_IF, w.valid_IF, w.thread_sel_ID, w.pc_ID, w.valid_ID},
               {4'h0, 9'h000, 1'b0, 4'h0, 9'h000, 1'b0});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({w.thread_sel_IF, w.pc_IF, w.valid_IF} !== {4'h1, 9'h1FF, 1'b1}) begin
      errors++;
      $display("FAIL reset_start_pc got=%h exp=%h", {w.thread_sel_IF, w.pc_IF, w.valid_IF}, {4'h1, 9'h1FF, 1'b1});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_enable_mask();
    test_redirect();
    test_halt();
    test_stall();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
